// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep sequencer: cfg word layout, sweep modes,
// state encoding and the clamped step helpers.
package dds_pkg;

  localparam int CFG_ON_BIT  = 31;
  localparam int CFG_INV_BIT = 30;
  localparam int PHASE_INC_W = 30;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2,
    HOLD     = 2'd3
  } sweep_state_t;

  typedef logic [PHASE_INC_W-1:0] phase_t;

  // The extra sum bit catches wrap-around so the top of the range clamps instead of folding.
  function automatic phase_t step_up(phase_t cur, phase_t step, phase_t stop);
    logic [PHASE_INC_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum[PHASE_INC_W] || (sum[PHASE_INC_W-1:0] >= stop))
      return stop;
    return sum[PHASE_INC_W-1:0];
  endfunction

  function automatic phase_t step_down(phase_t cur, phase_t step, phase_t floor_val);
    if ((cur - floor_val) < step)
      return floor_val;
    return cur - step;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that measures how long each sweep point is held.
module dwell_timer #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [DW-1:0] cnt_reg;

  // Load wins over decrement; the count parks at zero until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (load)
      cnt_reg <= load_val;
    else if (en && (cnt_reg != '0))
      cnt_reg <= cnt_reg - DW'(1);
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer producing the {dds_on, dds_inv, phase_inc} DDS word.
// Settings are shadowed on start; the first point appears one cycle later.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_INC_W-1:0] f_start,
  input  logic [PHASE_INC_W-1:0] f_stop,
  input  logic [PHASE_INC_W-1:0] f_step,
  input  logic [DW-1:0]          dwell,
  input  logic [1:0]             mode,
  input  logic                   inv,
  output logic [31:0]            cfg,
  output logic                   busy,
  output logic                   done
);

  sweep_state_t  state_reg;
  phase_t        cur_reg;
  phase_t        start_s_reg;
  phase_t        stop_s_reg;
  phase_t        step_s_reg;
  logic [DW-1:0] dwell_s_reg;
  logic [1:0]    mode_s_reg;
  logic          inv_s_reg;
  logic          inv_reg;
  logic          on_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          pend_reg;

  logic timer_zero;
  logic timer_load;
  logic running;
  logic dwell_end;
  logic degen;

  assign running    = (state_reg == RUN_UP) || (state_reg == RUN_DOWN);
  assign dwell_end  = running && timer_zero && !pend_reg;
  assign timer_load = !abort && !start && (pend_reg || dwell_end);
  assign degen      = (stop_s_reg <= start_s_reg);

  dwell_timer #(.DW(DW)) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (dwell_s_reg - DW'(1)),
    .en       (running),
    .zero     (timer_zero)
  );

  // Priority: abort, then a fresh start, then the one-cycle launch, then the sweep itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cur_reg     <= '0;
      start_s_reg <= '0;
      stop_s_reg  <= '0;
      step_s_reg  <= phase_t'(1);
      dwell_s_reg <= DW'(1);
      mode_s_reg  <= MODE_SINGLE;
      inv_s_reg   <= 1'b0;
      inv_reg     <= 1'b0;
      on_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      pend_reg    <= 1'b0;
    end else if (abort) begin
      state_reg <= IDLE;
      on_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      pend_reg  <= 1'b0;
    end else if (start) begin
      start_s_reg <= f_start;
      stop_s_reg  <= f_stop;
      step_s_reg  <= (f_step == '0) ? phase_t'(1) : f_step;
      dwell_s_reg <= (dwell == '0) ? DW'(1) : dwell;
      mode_s_reg  <= (mode == 2'b11) ? MODE_SINGLE : mode;
      inv_s_reg   <= inv;
      pend_reg    <= 1'b1;
      done_reg    <= 1'b0;
    end else if (pend_reg) begin
      pend_reg  <= 1'b0;
      state_reg <= RUN_UP;
      cur_reg   <= start_s_reg;
      inv_reg   <= inv_s_reg;
      on_reg    <= 1'b1;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (dwell_end) begin
        case (state_reg)
          RUN_UP: begin
            // cur >= stop also covers the degenerate single-point range
            if (cur_reg >= stop_s_reg) begin
              if (mode_s_reg == MODE_SINGLE) begin
                state_reg <= HOLD;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else if ((mode_s_reg == MODE_REPEAT) || degen) begin
                cur_reg  <= start_s_reg;
                done_reg <= 1'b1;
              end else begin
                state_reg <= RUN_DOWN;
                cur_reg   <= step_down(cur_reg, step_s_reg, start_s_reg);
              end
            end else begin
              cur_reg <= step_up(cur_reg, step_s_reg, stop_s_reg);
            end
          end
          RUN_DOWN: begin
            if (cur_reg <= start_s_reg) begin
              state_reg <= RUN_UP;
              cur_reg   <= step_up(start_s_reg, step_s_reg, stop_s_reg);
              done_reg  <= 1'b1;
            end else begin
              cur_reg <= step_down(cur_reg, step_s_reg, start_s_reg);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cfg                    = '0;
    cfg[CFG_ON_BIT]        = on_reg;
    cfg[CFG_INV_BIT]       = inv_reg;
    cfg[PHASE_INC_W-1:0]   = cur_reg;
  end

  assign busy = busy_reg;
  assign done = done_reg;

endmodule
